ramb16_s2_arbiter: RTL and testbench

- Sequences a single-port 8K x 2 block RAM (16 Kb primitive, 2-bit data) and shares it between two requesters, A and B.
- Grants per-cycle access using round-robin arbitration.
- Returns read data with a fixed latency.
- Provides a clear sequencer that fills every location with a constant.
- Sits directly between client logic and the RAM's ADDR/DI/EN/WE/DO pins. The RAM's SSR input is tied low outside this block.

---
 rtl/ramb16_s2_arbiter_if.sv | 52 +++++
 rtl/ramb16_s2_arbiter.sv | 104 ++++++++++
 tb/tb_ramb16_s2_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ramb16_s2_arbiter_if.sv
// Client/RAM-pin bundle for the two-requester 8K x 2 block RAM arbiter.
// The arbiter uses the slave view; the client/RAM side uses master.
interface ramb16_s2_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 2
);
  logic              A_REQ;
  logic              A_WE;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DI;
  logic              A_GNT;
  logic              A_RVALID;
  logic [DATA_W-1:0] A_DO;

  logic              B_REQ;
  logic              B_WE;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_DI;
  logic              B_GNT;
  logic              B_RVALID;
  logic [DATA_W-1:0] B_DO;

  logic              CLR_START;
  logic              CLR_BUSY;
  logic              CLR_DONE;

  logic              RAM_EN;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DI;
  logic [DATA_W-1:0] RAM_DO;

  modport slave (
    input  A_REQ, A_WE, A_ADDR, A_DI,
    input  B_REQ, B_WE, B_ADDR, B_DI,
    input  CLR_START, RAM_DO,
    output A_GNT, A_RVALID, A_DO,
    output B_GNT, B_RVALID, B_DO,
    output CLR_BUSY, CLR_DONE,
    output RAM_EN, RAM_WE, RAM_ADDR, RAM_DI
  );

  modport master (
    output A_REQ, A_WE, A_ADDR, A_DI,
    output B_REQ, B_WE, B_ADDR, B_DI,
    output CLR_START, RAM_DO,
    input  A_GNT, A_RVALID, A_DO,
    input  B_GNT, B_RVALID, B_DO,
    input  CLR_BUSY, CLR_DONE,
    input  RAM_EN, RAM_WE, RAM_ADDR, RAM_DI
  );
endinterface

// File: rtl/ramb16_s2_arbiter.sv
// Round-robin sharing of a single-port 8K x 2 block RAM between requesters
// A and B, with a full-array clear sequencer and one-cycle read latency.
module ramb16_s2_arbiter #(
  parameter int                ADDR_W = 13,
  parameter int                DATA_W = 2,
  parameter int                DEPTH  = 8192,
  parameter logic [DATA_W-1:0] FILL   = 2'b00
) (
  input logic                CLK,
  input logic                RST_N,
  ramb16_s2_arbiter_if.slave bus
);

  typedef enum logic {RUN, CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic              ptr_q;      // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic              done_q;
  logic              a_gnt;
  logic              b_gnt;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state_q == RUN) begin
      a_gnt = bus.A_REQ & (~bus.B_REQ | ~ptr_q);
      b_gnt = bus.B_REQ & (~bus.A_REQ |  ptr_q);
    end
  end

  assign cnt_d = cnt_q + 1'b1;

  always_comb begin
    bus.RAM_EN   = 1'b0;
    bus.RAM_WE   = 1'b0;
    bus.RAM_ADDR = '0;
    bus.RAM_DI   = '0;
    if (state_q == CLEAR) begin
      bus.RAM_EN   = 1'b1;
      bus.RAM_WE   = 1'b1;
      bus.RAM_ADDR = cnt_q;
      bus.RAM_DI   = FILL;
    end else if (a_gnt) begin
      bus.RAM_EN   = 1'b1;
      bus.RAM_WE   = bus.A_WE;
      bus.RAM_ADDR = bus.A_ADDR;
      bus.RAM_DI   = bus.A_DI;
    end else if (b_gnt) begin
      bus.RAM_EN   = 1'b1;
      bus.RAM_WE   = bus.B_WE;
      bus.RAM_ADDR = bus.B_ADDR;
      bus.RAM_DI   = bus.B_DI;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= RUN;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Grants are forced low in CLEAR, so a read issued just before the
      // clear still returns its RVALID during the first CLEAR cycle.
      a_rvalid_q <= a_gnt & ~bus.A_WE;
      b_rvalid_q <= b_gnt & ~bus.B_WE;
      done_q     <= 1'b0;
      case (state_q)
        RUN: begin
          if (a_gnt)      ptr_q <= 1'b1;
          else if (b_gnt) ptr_q <= 1'b0;
          if (bus.CLR_START) state_q <= CLEAR;
        end
        CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.A_GNT    = a_gnt;
  assign bus.B_GNT    = b_gnt;
  assign bus.A_RVALID = a_rvalid_q;
  assign bus.B_RVALID = b_rvalid_q;
  assign bus.A_DO     = bus.RAM_DO;
  assign bus.B_DO     = bus.RAM_DO;
  assign bus.CLR_BUSY = (state_q == CLEAR);
  assign bus.CLR_DONE = done_q;

endmodule

// File: tb/tb_ramb16_s2_arbiter.sv
// Directed bench for ramb16_s2_arbiter with a behavioural 8K x 2 RAM on the
// RAM pins; expected values are hand-computed per vector.
module tb_ramb16_s2_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  ramb16_s2_arbiter_if #(.ADDR_W(13), .DATA_W(2)) bus ();

  ramb16_s2_arbiter #(
    .ADDR_W(13),
    .DATA_W(2),
    .DEPTH (8192),
    .FILL  (2'b00)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mem [8192];

  always @(posedge clk) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DI;
      else            bus.RAM_DO <= mem[bus.RAM_ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int errs;
    int bgnts;
    n_checks     = 0;
    n_errs       = 0;
    bus.RAM_DO   = '0;
    rst_n        = 1'b0;
    bus.A_REQ    = 0; bus.A_WE = 0; bus.A_ADDR = '0; bus.A_DI = '0;
    bus.B_REQ    = 0; bus.B_WE = 0; bus.B_ADDR = '0; bus.B_DI = '0;
    bus.CLR_START = 0;

    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Pending read, then asynchronous reset mid-cycle
    bus.A_REQ = 1; bus.A_WE = 0; bus.A_ADDR = 13'h0005;
    #1 check("rst_pre_gnt", bus.A_GNT, 1);
    cyc();
    bus.A_REQ = 0;
    #1 check("rst_pre_rvalid", bus.A_RVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_rvalid", bus.A_RVALID, 0);
    check("rst_b_rvalid", bus.B_RVALID, 0);
    check("rst_a_gnt",    bus.A_GNT, 0);
    check("rst_b_gnt",    bus.B_GNT, 0);
    check("rst_ram_en",   bus.RAM_EN, 0);
    check("rst_ram_we",   bus.RAM_WE, 0);
    check("rst_ram_addr", bus.RAM_ADDR, 0);
    check("rst_busy",     bus.CLR_BUSY, 0);
    check("rst_done",     bus.CLR_DONE, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Contention from reset: A, B, A, B, then B alone twice
    bus.A_REQ = 1; bus.A_WE = 1; bus.A_ADDR = 13'h0010; bus.A_DI = 2'b01;
    bus.B_REQ = 1; bus.B_WE = 1; bus.B_ADDR = 13'h0020; bus.B_DI = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_a_gnt", bus.A_GNT, (i % 2 == 0) ? 1 : 0);
      check("cont_b_gnt", bus.B_GNT, (i % 2 == 1) ? 1 : 0);
      check("cont_ram_addr", bus.RAM_ADDR, (i % 2 == 0) ? 32'h10 : 32'h20);
      cyc();
    end
    bus.A_REQ = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bonly_a_gnt", bus.A_GNT, 0);
      check("bonly_b_gnt", bus.B_GNT, 1);
      cyc();
    end
    bus.B_REQ = 0;
    #1 check("idle_ram_en", bus.RAM_EN, 0);

    // B reads back its write
    bus.B_REQ = 1; bus.B_WE = 0; bus.B_ADDR = 13'h0020;
    #1 check("brd_gnt", bus.B_GNT, 1);
    cyc();
    bus.B_REQ = 0;
    #1;
    check("brd_rvalid", bus.B_RVALID, 1);
    check("brd_do", bus.B_DO, 2'b10);
    check("brd_a_rvalid", bus.A_RVALID, 0);

    // A writes 2'b11 @ 0x1ABC then reads it
    bus.A_REQ = 1; bus.A_WE = 1; bus.A_ADDR = 13'h1ABC; bus.A_DI = 2'b11;
    #1;
    check("wr_gnt", bus.A_GNT, 1);
    check("wr_ram_we", bus.RAM_WE, 1);
    check("wr_ram_addr", bus.RAM_ADDR, 32'h1ABC);
    check("wr_ram_di", bus.RAM_DI, 2'b11);
    cyc();
    bus.A_WE = 0;
    #1;
    check("rd_gnt", bus.A_GNT, 1);
    check("rd_ram_we", bus.RAM_WE, 0);
    check("wr_no_rvalid", bus.A_RVALID, 0);
    cyc();
    bus.A_REQ = 0;
    #1;
    check("rd_rvalid", bus.A_RVALID, 1);
    check("rd_do", bus.A_DO, 2'b11);
    check("rd_b_rvalid", bus.B_RVALID, 0);
    cyc();
    check("rd_rvalid_drop", bus.A_RVALID, 0);

    // Clear sweep
    bus.A_REQ = 1; bus.A_WE = 1; bus.A_ADDR = 13'h0000; bus.A_DI = 2'b10;
    cyc();
    bus.A_ADDR = 13'h1FFF;
    cyc();
    bus.A_REQ = 0;
    bus.CLR_START = 1;
    #1 check("clr_not_yet_busy", bus.CLR_BUSY, 0);
    cyc();
    bus.CLR_START = 0;
    n = 0; errs = 0;
    while (bus.CLR_BUSY && n < 9000) begin
      #1;
      if (bus.RAM_ADDR !== 13'(n) || bus.RAM_WE !== 1'b1 || bus.RAM_EN !== 1'b1 ||
          bus.RAM_DI !== 2'b00 || bus.CLR_DONE !== 1'b0) errs++;
      n++;
      cyc();
    end
    check("clr_busy_cycles", n, 8192);
    check("clr_sweep_errs", errs, 0);
    #1;
    check("clr_done", bus.CLR_DONE, 1);
    check("clr_busy_off", bus.CLR_BUSY, 0);
    cyc();
    check("clr_done_pulse", bus.CLR_DONE, 0);
    bus.A_REQ = 1; bus.A_WE = 0; bus.A_ADDR = 13'h0000;
    cyc();
    bus.A_ADDR = 13'h1FFF;
    #1;
    check("clr_rd0_rvalid", bus.A_RVALID, 1);
    check("clr_rd0_do", bus.A_DO, 2'b00);
    cyc();
    bus.A_REQ = 0;
    #1;
    check("clr_rdtop_rvalid", bus.A_RVALID, 1);
    check("clr_rdtop_do", bus.A_DO, 2'b00);
    cyc();

    // Clear started alongside a read grant; B waits out the clear
    bus.A_REQ = 1; bus.A_WE = 1; bus.A_ADDR = 13'h0007; bus.A_DI = 2'b01;
    cyc();
    bus.A_WE = 0;
    bus.CLR_START = 1;
    #1 check("ct_a_gnt", bus.A_GNT, 1);
    cyc();
    bus.A_REQ = 0; bus.CLR_START = 0;
    bus.B_REQ = 1; bus.B_WE = 0; bus.B_ADDR = 13'h0020;
    #1;
    check("ct_busy", bus.CLR_BUSY, 1);
    check("ct_a_rvalid", bus.A_RVALID, 1);
    check("ct_a_do", bus.A_DO, 2'b01);
    check("ct_ram_addr0", bus.RAM_ADDR, 0);
    n = 0; bgnts = 0;
    while (bus.CLR_BUSY && n < 9000) begin
      #1;
      if (bus.B_GNT !== 1'b0 || bus.A_GNT !== 1'b0) bgnts++;
      n++;
      cyc();
    end
    check("ct_busy_cycles", n, 8192);
    check("ct_gnt_during_clr", bgnts, 0);
    #1;
    check("ct_done", bus.CLR_DONE, 1);
    check("ct_b_gnt_at_done", bus.B_GNT, 1);
    cyc();
    bus.B_REQ = 0;
    #1 check("ct_b_rvalid", bus.B_RVALID, 1);
    cyc();

    // Reset in the middle of a clear
    bus.CLR_START = 1;
    cyc();
    bus.CLR_START = 0;
    n = 0;
    while (bus.RAM_ADDR !== 13'd100 && n < 200) begin
      cyc();
      n++;
    end
    check("mid_reach_100", bus.RAM_ADDR, 100);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", bus.CLR_BUSY, 0);
    check("mid_ram_en", bus.RAM_EN, 0);
    check("mid_done", bus.CLR_DONE, 0);
    cyc();
    rst_n = 1'b1;
    errs = 0;
    repeat (5) begin
      cyc();
      if (bus.CLR_DONE !== 1'b0 || bus.CLR_BUSY !== 1'b0) errs++;
    end
    check("mid_no_done", errs, 0);
    bus.CLR_START = 1;
    cyc();
    bus.CLR_START = 0;
    #1;
    check("restart_busy", bus.CLR_BUSY, 1);
    check("restart_addr0", bus.RAM_ADDR, 0);
    cyc();
    check("restart_addr1", bus.RAM_ADDR, 1);
    rst_n = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
